// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with req/ready handshake, WAIT wait states
// and a sticky memory-mapped done/result register at DONE_ADDR.
module dmem_responder #(
  parameter int          DEPTH     = 64,
  parameter int          WAIT      = 2,
  parameter logic [31:0] DONE_ADDR = 32'h64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        done,
  output logic [31:0] result
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_next;
  logic          w_accept;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_ready;
  logic          r_err;
  logic [31:0]   r_rdata;
  logic          r_done;
  logic [31:0]   r_result;
  logic [31:0]   r_mem [DEPTH];
  logic          w_commit;
  logic          w_dec_err;
  logic [AW-1:0] w_idx;

  // BUSY always spans WAIT+1 edges so ready lands exactly WAIT+1 edges after acceptance
  assign w_commit  = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_dec_err = (r_addr[1:0] != 2'd0) || (r_addr >= BYTE_LIMIT);
  assign w_idx     = r_addr[AW+1:2];

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_accept = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_next = RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (req) begin
          w_accept = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    if (w_accept) begin
      w_next     = BUSY;
      w_cnt_next = 4'(WAIT);
    end else begin
      w_cnt_next = w_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'd0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_ready <= w_commit;
      r_err   <= w_commit && w_dec_err;
      if (w_commit) begin
        if (w_dec_err) begin
          r_rdata <= 32'd0;
        end else if (!r_we) begin
          r_rdata <= r_mem[w_idx];
        end else if (r_addr == DONE_ADDR) begin
          r_done   <= 1'b1;
          r_result <= r_wdata;
        end
      end
    end
  end

  // RAM array is deliberately not reset; commit cannot happen while reset holds the FSM in IDLE
  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_dec_err) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign ready  = r_ready;
  assign err    = r_err;
  assign rdata  = r_rdata;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: three responders (WAIT=2, 0, 3) sharing a clock and bus.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        req0 = 1'b0, req2 = 1'b0, req3 = 1'b0;
  logic        rst0 = 1'b0, rst2 = 1'b0, rst3 = 1'b0;
  logic        rdy0, rdy2, rdy3, err0, err2, err3, done0, done2, done3;
  logic [31:0] rd0, rd2, rd3, res0, res2, res3;
  int          n_cmp = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT(0), .DONE_ADDR(32'h64)) u0 (
    .clk(clk), .reset(rst0), .req(req0), .we(we), .addr(addr), .wdata(wdata),
    .ready(rdy0), .rdata(rd0), .err(err0), .done(done0), .result(res0));
  dmem_responder #(.DEPTH(64), .WAIT(2), .DONE_ADDR(32'h64)) u2 (
    .clk(clk), .reset(rst2), .req(req2), .we(we), .addr(addr), .wdata(wdata),
    .ready(rdy2), .rdata(rd2), .err(err2), .done(done2), .result(res2));
  dmem_responder #(.DEPTH(64), .WAIT(3), .DONE_ADDR(32'h64)) u3 (
    .clk(clk), .reset(rst3), .req(req3), .we(we), .addr(addr), .wdata(wdata),
    .ready(rdy3), .rdata(rd3), .err(err3), .done(done3), .result(res3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic v);
    case (sel)
      0:       req0 = v;
      2:       req2 = v;
      default: req3 = v;
    endcase
  endtask

  function automatic logic rdy_of(input int sel);
    case (sel)
      0:       return rdy0;
      2:       return rdy2;
      default: return rdy3;
    endcase
  endfunction

  function automatic logic [31:0] rd_of(input int sel);
    case (sel)
      0:       return rd0;
      2:       return rd2;
      default: return rd3;
    endcase
  endfunction

  function automatic logic err_of(input int sel);
    case (sel)
      0:       return err0;
      2:       return err2;
      default: return err3;
    endcase
  endfunction

  // Single request; lat = edges from acceptance to ready (-1 if it never came)
  task automatic do_txn(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat);
    we = w; addr = a; wdata = d;
    set_req(sel, 1'b1);
    @(posedge clk); #1;
    set_req(sel, 1'b0);
    we = ~w; addr = 32'hFFFF_FFFC; wdata = 32'h0BAD_0BAD;
    lat = -1; rd = 32'd0; e = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (rdy_of(sel)) begin
        lat = n; rd = rd_of(sel); e = err_of(sel);
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      check("ready_one_cycle", 32'(rdy_of(sel)), 32'd0);
    end
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  logic        saw_ready;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(rdy2), 32'd0);
    check("rst_err", 32'(err2), 32'd0);
    check("rst_rdata", rd2, 32'd0);
    check("rst_done", 32'(done2), 32'd0);
    check("rst_result", res2, 32'd0);
    check("rst_ready0", 32'(rdy0), 32'd0);
    rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    @(posedge clk); #1;

    // WAIT=2 store/load
    do_txn(2, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, e, lat);
    check("w2_st_lat", 32'(lat), 32'd3);
    check("w2_st_err", 32'(e), 32'd0);
    do_txn(2, 1'b0, 32'h10, 32'd0, rd, e, lat);
    check("w2_ld_lat", 32'(lat), 32'd3);
    check("w2_ld_rdata", rd, 32'hDEAD_BEEF);
    check("w2_ld_err", 32'(e), 32'd0);

    // done/result register
    check("done_before", 32'(done2), 32'd0);
    do_txn(2, 1'b1, 32'h64, 32'h1000, rd, e, lat);
    check("done_set", 32'(done2), 32'd1);
    check("result_1000", res2, 32'h1000);
    do_txn(2, 1'b1, 32'h64, 32'd7, rd, e, lat);
    check("result_7", res2, 32'd7);
    check("done_sticky", 32'(done2), 32'd1);
    do_txn(2, 1'b0, 32'h64, 32'd0, rd, e, lat);
    check("ld_done_addr", rd, 32'd7);

    // errors leave RAM and done untouched; stores keep rdata
    do_txn(2, 1'b1, 32'h60, 32'h55AA, rd, e, lat);
    check("st_keeps_rdata", rd, 32'd7);
    do_txn(2, 1'b1, 32'h62, 32'h1234_5678, rd, e, lat);
    check("misalign_err", 32'(e), 32'd1);
    check("misalign_rdata", rd, 32'd0);
    do_txn(2, 1'b0, 32'h100, 32'd0, rd, e, lat);
    check("range_err", 32'(e), 32'd1);
    check("range_rdata", rd, 32'd0);
    check("range_lat", 32'(lat), 32'd3);
    do_txn(2, 1'b0, 32'h60, 32'd0, rd, e, lat);
    check("word60_kept", rd, 32'h55AA);
    check("word60_err", 32'(e), 32'd0);
    check("done_after_err", 32'(done2), 32'd1);
    check("result_after_err", res2, 32'd7);

    // WAIT=0 preload then back-to-back loads with req held
    for (int i = 0; i < 4; i++) begin
      do_txn(0, 1'b1, 32'(4 * i), 32'(i + 1), rd, e, lat);
      check("w0_st_lat", 32'(lat), 32'd1);
    end
    we = 1'b0;
    req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'(4 * i);
      @(posedge clk); #1;
      addr = 32'hFFFF_FFFC;
      check("b2b_gap", 32'(rdy0), 32'd0);
      @(posedge clk); #1;
      check("b2b_ready", 32'(rdy0), 32'd1);
      check("b2b_rdata", rd0, 32'(i + 1));
    end
    req0 = 1'b0;
    @(posedge clk); #1;
    check("b2b_end", 32'(rdy0), 32'd0);

    // WAIT=3 store aborted by reset
    do_txn(3, 1'b1, 32'h20, 32'h11, rd, e, lat);
    check("w3_st_lat", 32'(lat), 32'd4);
    we = 1'b1; addr = 32'h20; wdata = 32'hA5; req3 = 1'b1;
    @(posedge clk); #1;
    req3 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst3 = 1'b0;
    #1;
    check("abort_ready", 32'(rdy3), 32'd0);
    check("abort_err", 32'(err3), 32'd0);
    check("abort_rdata", rd3, 32'd0);
    check("abort_done", 32'(done3), 32'd0);
    check("abort_result", res3, 32'd0);
    @(posedge clk); #1;
    rst3 = 1'b1;
    saw_ready = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (rdy3) saw_ready = 1'b1;
    end
    check("abort_no_ready", 32'(saw_ready), 32'd0);
    do_txn(3, 1'b0, 32'h20, 32'd0, rd, e, lat);
    check("abort_no_write", rd, 32'h11);
    check("abort_ld_lat", 32'(lat), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
